// File: rtl/runner_frame_ctrl_if.sv
// Request/response bundle between the running-man sequencer and its pixel datapath.
// The master side is the sequencer; the slave side is the datapath plus user inputs.
interface runner_frame_ctrl_if;
   logic       frame_tick;
   logic       jump_btn;
   logic       crouch_btn;
   logic       draw_floors_finish;
   logic       draw_man_finish;
   logic       erase_finish;
   logic       drawing_floors;
   logic       draw_man;
   logic       erase;
   logic [7:0] x_original;
   logic [6:0] y_original;
   logic       normal1crouch0;
   logic [1:0] lane;
   logic       timeout_err;
   logic       busy;

   modport master (
      input  frame_tick, jump_btn, crouch_btn,
      input  draw_floors_finish, draw_man_finish, erase_finish,
      output drawing_floors, draw_man, erase,
      output x_original, y_original, normal1crouch0, lane,
      output timeout_err, busy
   );

   modport slave (
      output frame_tick, jump_btn, crouch_btn,
      output draw_floors_finish, draw_man_finish, erase_finish,
      input  drawing_floors, draw_man, erase,
      input  x_original, y_original, normal1crouch0, lane,
      input  timeout_err, busy
   );
endinterface

// File: rtl/runner_frame_ctrl.sv
// Sequencer for the running-man datapath: floors once, then draw / wait / erase / update forever.
// Owns the sprite anchor, pose, lane and jump state; issues one datapath request at a time.
module runner_frame_ctrl #(
   parameter int FRAMES_PER_STEP = 4,
   parameter int X_MIN           = 2,
   parameter int X_MAX           = 154,
   parameter int JUMP_H          = 8,
   parameter int JUMP_STEPS      = 6,
   parameter int DONE_TIMEOUT    = 255
) (
   input logic                 clk,
   input logic                 reset_n,
   runner_frame_ctrl_if.master bus
);
   localparam int FCW = $clog2(FRAMES_PER_STEP + 1);
   localparam int JCW = $clog2(JUMP_STEPS + 1);
   localparam int WDW = $clog2(DONE_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_FLOORS,
      S_DRAW,
      S_WAIT,
      S_ERASE,
      S_UPDATE
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       x_q, x_d;
   logic [6:0]       y_q, y_d;
   logic             pose_q, pose_d;
   logic [1:0]       lane_q, lane_d;
   logic [JCW-1:0]   jump_cnt_q, jump_cnt_d;
   logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
   logic [WDW-1:0]   wd_q, wd_d;
   logic             terr_q, terr_d;
   logic             busy_q, busy_d;
   // Request and finish vectors share indexing: 0 floors, 1 draw, 2 erase.
   logic [2:0]       req_q, req_d;
   logic [2:0]       fin_r_q, fin_r_d;
   logic [2:0]       fin_prev_q, fin_prev_d;
   logic             first_q, first_d;
   logic             arm_q, arm_d;

   logic [2:0]       fin_raw;
   logic [2:0]       fin_edge;
   logic             fin_done;
   logic             wd_expire;
   logic             req_done;
   logic [7:0]       upd_x;
   logic [1:0]       upd_lane;
   logic [JCW-1:0]   upd_jc;

   assign fin_raw = {bus.erase_finish, bus.draw_man_finish, bus.draw_floors_finish};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_fin
         assign fin_edge[gi] = fin_r_q[gi] & ~fin_prev_q[gi];
      end
   endgenerate

   // Finish flags are sticky in the datapath: only a fresh edge counts, except a
   // flag already high when the request opens, which is accepted one cycle later.
   assign fin_done  = ~first_q & ((|(fin_edge & req_q)) | arm_q);
   assign wd_expire = (|req_q) & (wd_q == WDW'(DONE_TIMEOUT - 1));
   assign req_done  = fin_done | wd_expire;

   function automatic logic [6:0] stand_y(input logic [1:0] l);
      case (l)
         2'd1:    stand_y = 7'(75 - 7);
         2'd2:    stand_y = 7'(115 - 7);
         default: stand_y = 7'(35 - 7);
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      pose_d      = pose_q;
      lane_d      = lane_q;
      jump_cnt_d  = jump_cnt_q;
      frame_cnt_d = frame_cnt_q;
      terr_d      = terr_q | (wd_expire & ~fin_done);
      upd_x       = x_q;
      upd_lane    = lane_q;
      upd_jc      = jump_cnt_q;

      case (state_q)
         S_FLOORS: if (req_done) state_d = S_DRAW;
         S_DRAW:   if (req_done) state_d = S_WAIT;
         S_WAIT: begin
            if (bus.frame_tick) begin
               if (frame_cnt_q == FCW'(FRAMES_PER_STEP - 1)) begin
                  frame_cnt_d = '0;
                  state_d     = S_ERASE;
               end else begin
                  frame_cnt_d = frame_cnt_q + FCW'(1);
               end
            end
         end
         S_ERASE:  if (req_done) state_d = S_UPDATE;
         S_UPDATE: begin
            if (x_q == 8'(X_MAX)) begin
               upd_x    = 8'(X_MIN);
               upd_lane = (lane_q == 2'd2) ? 2'd0 : lane_q + 2'd1;
               upd_jc   = '0;
            end else begin
               upd_x    = x_q + 8'd1;
            end
            // A crouch held together with jump keeps the runner on the ground.
            if (upd_jc == '0 && bus.jump_btn && pose_q && !bus.crouch_btn)
               upd_jc = JCW'(JUMP_STEPS);
            if (upd_jc != '0) begin
               y_d        = stand_y(upd_lane) - 7'(JUMP_H);
               jump_cnt_d = upd_jc - JCW'(1);
               pose_d     = 1'b1;
            end else begin
               y_d        = stand_y(upd_lane);
               jump_cnt_d = '0;
               pose_d     = ~bus.crouch_btn;
            end
            x_d     = upd_x;
            lane_d  = upd_lane;
            state_d = S_DRAW;
         end
         default: state_d = S_FLOORS;
      endcase

      if (!reset_n) begin
         state_d     = S_FLOORS;
         x_d         = 8'(X_MIN);
         y_d         = stand_y(2'd0);
         pose_d      = 1'b1;
         lane_d      = 2'd0;
         jump_cnt_d  = '0;
         frame_cnt_d = '0;
         terr_d      = 1'b0;
      end

      req_d      = {state_d == S_ERASE, state_d == S_DRAW, state_d == S_FLOORS} & {3{reset_n}};
      busy_d     = (state_d != S_WAIT);
      first_d    = (|req_d) && ((state_d != state_q) || !(|req_q));
      arm_d      = reset_n & first_q & (|(fin_raw & req_q));
      fin_r_d    = reset_n ? fin_raw : 3'b000;
      fin_prev_d = reset_n ? fin_r_q : 3'b000;
      if (!reset_n || state_d != state_q)
         wd_d = '0;
      else if (|req_q)
         wd_d = wd_q + WDW'(1);
      else
         wd_d = wd_q;
   end

   always_ff @(posedge clk) begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pose_q      <= pose_d;
      lane_q      <= lane_d;
      jump_cnt_q  <= jump_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      wd_q        <= wd_d;
      terr_q      <= terr_d;
      busy_q      <= busy_d;
      req_q       <= req_d;
      fin_r_q     <= fin_r_d;
      fin_prev_q  <= fin_prev_d;
      first_q     <= first_d;
      arm_q       <= arm_d;
   end

   assign bus.drawing_floors = req_q[0];
   assign bus.draw_man       = req_q[1];
   assign bus.erase          = req_q[2];
   assign bus.x_original     = x_q;
   assign bus.y_original     = y_q;
   assign bus.normal1crouch0 = pose_q;
   assign bus.lane           = lane_q;
   assign bus.timeout_err    = terr_q;
   assign bus.busy           = busy_q;
endmodule

// File: tb/tb_runner_frame_ctrl.sv
// Scoreboard bench for runner_frame_ctrl: the stimulus queues each expected datapath request,
// a monitor pops and checks it when the request rises and checks its length when it drops.
module tb_runner_frame_ctrl;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   runner_frame_ctrl_if bus ();
   runner_frame_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   typedef struct {
      int kind;   // 0 floors, 1 draw, 2 erase
      int x;
      int y;
      int pose;
      int lane;
      int len;    // cycles the request stays high, 0 = not checked
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   endtask

   function automatic int sig(input int k);
      case (k)
         0:       return int'(bus.drawing_floors);
         1:       return int'(bus.draw_man);
         2:       return int'(bus.erase);
         default: return int'(bus.busy);
      endcase
   endfunction

   task automatic wait_sig(input int k, input int lvl, input int budget, input string name);
      if (sig(k) == lvl) return;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (sig(k) == lvl) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait_%s: level %0d not seen within %0d cycles", name, lvl, budget);
      finish_run();
   endtask

   task automatic push(input int k, input int x, input int y, input int p, input int l, input int len);
      exp_t e;
      e.kind = k; e.x = x; e.y = y; e.pose = p; e.lane = l; e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic chk_reset();
      chk("rst_floors", int'(bus.drawing_floors), 0);
      chk("rst_draw",   int'(bus.draw_man), 0);
      chk("rst_erase",  int'(bus.erase), 0);
      chk("rst_x",      int'(bus.x_original), 2);
      chk("rst_y",      int'(bus.y_original), 28);
      chk("rst_lane",   int'(bus.lane), 0);
      chk("rst_pose",   int'(bus.normal1crouch0), 1);
      chk("rst_terr",   int'(bus.timeout_err), 0);
      chk("rst_busy",   int'(bus.busy), 1);
   endtask

   // One animation step: expected draw, four frame ticks, expected erase, then the
   // buttons that the following update samples. ed < 0 withholds erase_finish.
   task automatic step(input int x, input int y, input int p, input int l,
                       input bit first, input bit jb, input bit cb, input int ed);
      push(1, x, y, p, l, first ? 5 : 2);
      wait_sig(1, 1, 40, "draw");
      bus.jump_btn   = 1'b0;
      bus.crouch_btn = 1'b0;
      if (first) begin
         repeat (3) begin @(posedge clk); #1; end
         bus.draw_man_finish = 1'b1;
      end
      wait_sig(3, 0, 40, "wait_state");
      repeat (3) tick();
      chk("erase_early", int'(bus.erase), 0);
      push(2, x, y, p, l, (ed < 0) ? 255 : ed + 2);
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      wait_sig(2, 1, 4, "erase");
      bus.jump_btn   = jb;
      bus.crouch_btn = cb;
      if (ed >= 0) begin
         repeat (ed) begin @(posedge clk); #1; end
         bus.erase_finish = 1'b1;
         @(posedge clk); #1;
         bus.erase_finish = 1'b0;
      end else begin
         wait_sig(2, 0, 300, "erase_timeout");
         chk("timeout_err", int'(bus.timeout_err), 1);
      end
   endtask

   initial begin : monitor
      logic [2:0] cur;
      logic [2:0] prev;
      exp_t       e;
      bit         active;
      int         len;
      int         k;
      int         txn;
      prev = 3'b000; active = 0; len = 0; txn = 0;
      e.kind = 0; e.x = 0; e.y = 0; e.pose = 0; e.lane = 0; e.len = 0;
      forever begin
         @(negedge clk);
         cur = {bus.erase, bus.draw_man, bus.drawing_floors};
         if (active) begin
            if (cur[e.kind]) len++;
            else begin
               if (e.len != 0) chk($sformatf("len_t%0d", txn), len, e.len);
               active = 0;
            end
         end
         if ((cur & ~prev) != 3'b000) begin
            chk("exclusive", $countones(cur), 1);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_req: request %b, expected nothing", cur);
            end else begin
               e = exp_q.pop_front();
               k = cur[0] ? 0 : (cur[1] ? 1 : 2);
               txn++;
               $display("txn %0d: kind=%0d x=%0d y=%0d pose=%0d lane=%0d", txn, k,
                        bus.x_original, bus.y_original, bus.normal1crouch0, bus.lane);
               chk($sformatf("kind_t%0d", txn), k, e.kind);
               chk($sformatf("x_t%0d", txn), int'(bus.x_original), e.x);
               chk($sformatf("y_t%0d", txn), int'(bus.y_original), e.y);
               chk($sformatf("pose_t%0d", txn), int'(bus.normal1crouch0), e.pose);
               chk($sformatf("lane_t%0d", txn), int'(bus.lane), e.lane);
               active = 1;
               len    = 1;
            end
         end
         prev = cur;
      end
   end

   initial begin : stim
      reset_n                = 1'b0;
      bus.frame_tick         = 1'b0;
      bus.jump_btn           = 1'b0;
      bus.crouch_btn         = 1'b0;
      bus.draw_floors_finish = 1'b0;
      bus.draw_man_finish    = 1'b0;
      bus.erase_finish       = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      chk_reset();

      // Floors: finish pulsed 20 cycles into the request, ticks here must be ignored.
      push(0, 2, 28, 1, 0, 22);
      reset_n = 1'b1;
      wait_sig(0, 1, 10, "floors");
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         bus.frame_tick = (i < 20) && (i % 2 == 1);
      end
      bus.draw_floors_finish = 1'b1;
      @(posedge clk); #1;
      bus.draw_floors_finish = 1'b0;

      // Jump on the first update, crouch held mid-jump, then crouch+jump on the ground.
      step(2, 28, 1, 0, 1'b1, 1'b1, 1'b0, 0);
      for (int s = 1; s <= 6; s++) step(2 + s, 20, 1, 0, 1'b0, 1'b0, (s == 2), s % 3);
      step(9, 28, 1, 0, 1'b0, 1'b1, 1'b1, -1);
      step(10, 28, 0, 0, 1'b0, 1'b1, 1'b0, 1);
      for (int s = 9; s <= 152; s++) step(2 + s, 28, 1, 0, 1'b0, 1'b0, 1'b0, s % 3);
      for (int s = 0; s <= 152; s++) step(2 + s, 68, 1, 1, 1'b0, 1'b0, 1'b0, s % 3);
      for (int s = 0; s <= 152; s++) step(2 + s, 108, 1, 2, 1'b0, 1'b0, 1'b0, s % 3);
      step(2, 28, 1, 0, 1'b0, 1'b0, 1'b0, 2);

      // Reset on the first cycle of a draw at x=3.
      push(1, 3, 28, 1, 0, 1);
      wait_sig(1, 1, 40, "draw_before_reset");
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk_reset();
      reset_n = 1'b1;

      push(0, 2, 28, 1, 0, 7);
      wait_sig(0, 1, 10, "floors_again");
      repeat (5) begin @(posedge clk); #1; end
      bus.draw_floors_finish = 1'b1;
      @(posedge clk); #1;
      bus.draw_floors_finish = 1'b0;
      push(1, 2, 28, 1, 0, 2);
      wait_sig(1, 1, 40, "draw_after_reset");
      wait_sig(3, 0, 40, "wait_after_reset");
      @(negedge clk); #1;
      chk("queue_empty", exp_q.size(), 0);
      finish_run();
   end
endmodule

// File: doc/runner_frame_ctrl.md
Name: runner_frame_ctrl

Overview:
- Top-level sequencer for the running-man pixel datapath.
- After reset it requests the three floor bands once. It then loops per animation step: draw man, wait N frame ticks, erase man, update position/pose.
- Owns the man's anchor (x_original, y_original), the pose select, lane progression, and jump/crouch input handling. Only one datapath request is active at any time.

Parameters:
- FRAMES_PER_STEP, 4, frame_tick pulses held in S_WAIT before erasing.
- X_MIN, 2, leftmost legal anchor x (sprite extends to x-2).
- X_MAX, 154, rightmost legal anchor x (sprite extends to x+5).
- JUMP_H, 8, rows the anchor rises during a jump.
- JUMP_STEPS, 6, animation steps spent airborne.
- DONE_TIMEOUT, 255, cycles to wait for a datapath finish before forcing progress.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- jump_btn  in  1  synchronised jump request, level
- crouch_btn  in  1  synchronised crouch request, level
- draw_floors_finish  in  1  datapath floor-draw complete (may stay high)
- draw_man_finish  in  1  datapath sprite-draw complete (may stay high)
- erase_finish  in  1  datapath sprite-erase complete (may stay high)
- drawing_floors  out  1  floor-draw request, level
- draw_man  out  1  sprite-draw request, level
- erase  out  1  sprite-erase request, level
- x_original  out  8  sprite anchor x
- y_original  out  7  sprite anchor y
- normal1crouch0  out  1  pose select: 1 = standing, 0 = crouched
- lane  out  2  current floor lane, 0..2
- timeout_err  out  1  sticky: a finish was never seen
- busy  out  1  high in every state except S_WAIT

Behaviour:
- Reset is synchronous active-low on reset_n, clock clk. While reset_n=0 every output takes its reset value:
  - state=S_FLOORS; all requests 0
  - x_original=X_MIN, y_original=28, lane=0
  - normal1crouch0=1, timeout_err=0, busy=1
  - jump counter=0, frame counter=0, watchdog=0
- Lane floor tops are 35/75/115. Standing anchor y = floor top − 7, i.e. 28/68/108.
- Finish detection:
  - Each *_finish input is registered. Completion = rising edge (prev=0, now=1). The datapath's finish flags are sticky, so a level must not be trusted.
  - Exception: a finish already high on the cycle the request first asserts counts as complete on the following cycle.
- Watchdog: counts cycles while any request is high. On reaching DONE_TIMEOUT it is treated as completion and timeout_err is set to 1, sticky until reset. It clears on every state change.
- States:
  - S_FLOORS: drawing_floors=1. On completion go to S_DRAW; drawing_floors drops in the same cycle as the transition. Entered only from reset.
  - S_DRAW: draw_man=1 with anchor and pose held stable. On completion go to S_WAIT.
  - S_WAIT: no request, busy=0. Counts frame_tick pulses; on the FRAMES_PER_STEP-th pulse go to S_ERASE and clear the counter.
  - S_ERASE: erase=1, same anchor and pose as the preceding draw. On completion go to S_UPDATE.
  - S_UPDATE: one cycle; computes the next anchor and pose, then goes to S_DRAW.
- Update rules, evaluated in order in S_UPDATE:
  1. x: x+1. If x==X_MAX, x wraps to X_MIN and lane advances 0→1→2→0. Jump counter is forced to 0 on a lane change.
  2. Jump start: jump counter==0, jump_btn=1 and normal1crouch0 was 1 → load JUMP_STEPS.
  3. Jump active (counter>0): y = standing y − JUMP_H; counter decrements by 1. The step where the counter reaches 0 restores standing y on the next update.
  4. Not jumping: y = standing y of the current lane.
  5. Pose: normal1crouch0 = ~crouch_btn, sampled here. Forced to 1 while jumping.
  6. Simultaneous jump_btn and crouch_btn on the ground: crouch wins, no jump.
- Request lines are mutually exclusive; at most one is high in any cycle.
- Anchor and pose change only in S_UPDATE, so a draw/erase pair always uses identical coordinates.
- frame_tick outside S_WAIT is ignored and not counted.
- Arithmetic: y_original is 7-bit unsigned; JUMP_H is chosen so y never underflows (28 − 8 = 20). x never exceeds X_MAX.
- Reset asserted mid-operation, including mid-request: all requests drop on the next edge and the sequence restarts at S_FLOORS.

Test Plan:
- Reset, then release; pulse draw_floors_finish after 20 cycles → drawing_floors 1 for exactly those cycles, then draw_man=1 with x=2, y=28, lane=0.
- Hold draw_man_finish high permanently after the first pulse; give 4 frame_ticks → erase asserts; sticky-high finish does not skip any later draw step.
- Run until x=154 and complete one update → x=2, lane=1, y=68; repeat at lane 2 → lane=0, y=28.
- jump_btn held for one update on lane 0 → y=20 for 6 draw/erase cycles, then y=28. crouch_btn during the jump keeps normal1crouch0=1.
- jump_btn and crouch_btn together on the ground → normal1crouch0=0, y unchanged at standing. Never pulse erase_finish → after 255 cycles the FSM advances to S_UPDATE and timeout_err=1.
- Assert reset_n=0 for one cycle while draw_man=1 → next cycle all requests 0, state S_FLOORS, x=2, y=28, timeout_err=0.
